ring_osc_freq_meter: RTL and testbench
======================================

# ring_osc_freq_meter

Single-clock frequency meter for the divided ring-oscillator outputs (e.g. counter-divided taps on `uo_out[4]`/`uo_out[5]`). It synchronises an asynchronous oscillator signal into the `clk` domain and counts its rising edges over a programmable gate window. It then publishes the edge count, so the on-chip oscillator rate becomes readable as `count / gate_cycles × f_clk`. It sits alongside the oscillator rings and is driven from `ui_in`, with results on `uo_out`/`uio_out`.

## Interface
- `GATE_W`, default 16: width of the gate-window length.
- `CNT_W`, default 16: width of the edge accumulator and result.
- `clk` in, 1 bit: measurement clock; the only clock in the block.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `osc_in` in, 1 bit: asynchronous oscillator signal; valid only when its frequency is ≤ f_clk/4.
- `start` in, 1 bit: request a measurement; sampled only in IDLE.
- `stop` in, 1 bit: ends continuous mode; ignored without `FREQ_METER_CONTINUOUS_EN`.
- `gate_cycles` in, `GATE_W` bits: window length in clk cycles; latched on accept; 0 is treated as 1.
- `busy` out, 1 bit: high while a window is open.
- `done` out, 1 bit: one-cycle pulse when `count` updates.
- `count` out, `CNT_W` bits: rising edges counted in the last completed window.
- `overflow` out, 1 bit: the last window saturated the accumulator.

## Operation
- **Synchroniser:** 2-FF synchroniser `s1→s2`, then a history register `s3`. `rise = s2 & ~s3`. All three registers reset to 0.
- **FSM states:** IDLE, MEASURE, DONE.
- **IDLE:** on `start`=1:
  - latch `gate_cycles` (0→1) into `remaining`;
  - clear `acc` and `ovf_acc`;
  - go to MEASURE.
- **MEASURE:** every cycle:
  - if `rise`, then `acc` += 1, saturating at 2^CNT_W−1; a `rise` seen while `acc` is at max sets `ovf_acc`;
  - `remaining` −= 1;
  - when `remaining` == 1 this cycle, go to DONE.
- **DONE (one cycle):** `count` ← `acc`, `overflow` ← `ovf_acc`, `done` = 1. Next state is IDLE (see Configuration).
- **Stable results:** `count` and `overflow` change only in DONE and hold otherwise.
- **Ignored inputs:**
  - `start` outside IDLE;
  - `gate_cycles` changes after the latch.
- **Dropped edges:** a `rise` in IDLE or DONE is not counted.
- **Reset:** asynchronous, at any time, including mid-window:
  - FSM goes to IDLE;
  - `acc`, `remaining`, `count` = 0;
  - `busy`, `done`, `overflow` = 0;
  - no `done` pulse is issued for the aborted window.

## Timing
- **Reset values:** `busy`=0, `done`=0, `count`=0, `overflow`=0.
- **Start and window:** `start` sampled high at edge T (IDLE) → MEASURE for cycles T+1 … T+G, where G is the latched window. `busy`=1 for exactly those G cycles.
- **Completion:** DONE at cycle T+G+1: `done`=1 and new `count` visible in that same cycle. Back to IDLE at T+G+2.
- **Edge latency:** an `osc_in` rising edge sampled at clk edge k produces `rise` in cycle k+2. It is counted if that cycle lies in T+1 … T+G.
- **Earliest restart:** next `start` can be accepted in cycle T+G+2.
- **Outputs:** all registered; no combinational path from input to output.

## Configuration
- **`FREQ_METER_CONTINUOUS_EN` defined:**
  - DONE goes straight back to MEASURE, re-latching the current `gate_cycles`.
  - `done` pulses every G+1 cycles; `busy` stays 1 except in the DONE cycle.
  - `stop`=1 sampled in any cycle of a window makes that window's DONE return to IDLE.
- **Undefined:** single-shot only; DONE → IDLE; `stop` is unused.

## Test plan
- **Basic count:** bench drives `osc_in` synchronously on negedge, period 8 clk with first rise 1 cycle after the `start` edge; `gate_cycles`=80 → `done` at T+81, `count`=10, `overflow`=0.
- **Saturation:** `CNT_W`=4, `osc_in` period 4, `gate_cycles`=100 → `count`=15, `overflow`=1.
- **Zero window:** `gate_cycles`=0, `osc_in` static → `busy` for 1 cycle, `done` at T+2, `count`=0.
- **Ignored inputs:** `start` pulsed and `gate_cycles` changed to 5 during a 40-cycle window → single `done` at T+41, result unaffected, no second window.
- **Reset mid-window:** `rst` asserted at T+20 of a 50-cycle window →
  - immediately `busy`=0, `count`=0, `done`=0;
  - no `done` pulse follows;
  - a fresh `start` measures normally.
- **Continuous mode** (`FREQ_METER_CONTINUOUS_EN`, `gate_cycles`=16, `osc_in` period 4) →
  - `done` pulses every 17 cycles, each with `count`=4;
  - `stop` raised once → exactly one more `done`, then IDLE.

Source files
------------

// File: rtl/ring_osc_freq_meter.sv
// ring_osc_freq_meter
//   Counts rising edges of an asynchronous, divided ring-oscillator signal
//   over a programmable window of clk cycles and publishes the edge count.
//   Oscillator rate = count / gate_cycles * f_clk.
//
// Optional feature macro: FREQ_METER_CONTINUOUS_EN
//   When defined, windows repeat back to back until stop is seen.
//   When undefined, each start runs one window and stop is unused.
//
// Ports
//   clk          measurement clock, the only clock in the block
//   rst          asynchronous active-high reset
//   osc_in       asynchronous oscillator input (must be <= f_clk/4)
//   start        request a measurement, sampled only in IDLE
//   stop         end continuous mode after the current window
//   gate_cycles  window length in clk cycles, latched on accept, 0 -> 1
//   busy         high while a window is open
//   done         one-cycle pulse when count/overflow update
//   count        rising edges counted in the last completed window
//   overflow     last window saturated the accumulator
module ring_osc_freq_meter #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_in,
  input  logic              start,
  input  logic              stop,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  state_t            state;
  logic              s1, s2, s3;
  logic              rise;
  logic [GATE_W-1:0] remaining;
  logic [GATE_W-1:0] gate_eff;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_nxt;
  logic              ovf_acc;
  logic              ovf_nxt;

  // Two-flop synchroniser followed by a history flop for edge detection.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign gate_eff = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;

  // Saturating accumulator update; a rise that cannot be added flags overflow.
  // NOTE: every output of this block gets a default first, so no latch forms
  // on the paths where rise is low.
  always_comb begin
    acc_nxt = acc;
    ovf_nxt = ovf_acc;
    if (rise) begin
      if (acc == ACC_MAX) ovf_nxt = 1'b1;
      else                acc_nxt = acc + CNT_W'(1);
    end
  end

`ifdef FREQ_METER_CONTINUOUS_EN
  logic stop_seen;
`else
  logic unused_stop;
  assign unused_stop = stop;
`endif

  // Results are loaded on the edge that enters DONE, so done and the new
  // count are visible together during the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef FREQ_METER_CONTINUOUS_EN
      stop_seen <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= gate_eff;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            busy      <= 1'b1;
            state     <= MEASURE;
`ifdef FREQ_METER_CONTINUOUS_EN
            stop_seen <= 1'b0;
`endif
          end
        end

        MEASURE: begin
          acc       <= acc_nxt;
          ovf_acc   <= ovf_nxt;
          remaining <= remaining - GATE_W'(1);
`ifdef FREQ_METER_CONTINUOUS_EN
          stop_seen <= stop_seen | stop;
`endif
          if (remaining == GATE_W'(1)) begin
            count    <= acc_nxt;
            overflow <= ovf_nxt;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end

        DONE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
          // Re-arm immediately unless stop arrived during the window just ended.
          if (stop_seen) begin
            state <= IDLE;
          end else begin
            remaining <= gate_eff;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            stop_seen <= 1'b0;
            busy      <= 1'b1;
            state     <= MEASURE;
          end
`else
          state <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Self-checking bench for ring_osc_freq_meter. Two instances share stimulus:
// a 16-bit accumulator and a 4-bit one to exercise saturation. Expected
// results come from a record of osc_in as sampled on every clk edge: a rising
// edge sampled at edge k is counted when k+2 falls inside the window.
// With FREQ_METER_CONTINUOUS_EN defined the continuous-mode section also runs.
module tb_ring_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        osc_in;
  logic        start;
  logic        stop;
  logic [15:0] gate_cycles;

  logic        busy16, done16, ovf16;
  logic [15:0] count16;
  logic        busy4, done4, ovf4;
  logic [3:0]  count4;

  int errors = 0;
  int checks = 0;

  // osc_in sample history indexed by clk edge number
  int cyc = 0;
  bit hist [0:4095];

  // oscillator pattern: period osc_p (0 = static low), phase origin osc_ref
  int osc_p   = 0;
  int osc_ref = 0;

  ring_osc_freq_meter #(.GATE_W(16), .CNT_W(16)) u16 (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .stop(stop),
    .gate_cycles(gate_cycles), .busy(busy16), .done(done16),
    .count(count16), .overflow(ovf16)
  );

  ring_osc_freq_meter #(.GATE_W(16), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .stop(stop),
    .gate_cycles(gate_cycles), .busy(busy4), .done(done4),
    .count(count4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc + 1 < 4096) hist[cyc + 1] <= rst ? 1'b0 : osc_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and drive the oscillator pattern.
  task automatic tick();
    @(negedge clk);
    if (osc_p != 0 && cyc >= osc_ref)
      osc_in = ((cyc - osc_ref) % osc_p) < (osc_p / 2);
    else
      osc_in = 1'b0;
  endtask

  // Edges counted for a window accepted at edge t with requested length g.
  function automatic int edges_in(input int t, input int g);
    int n;
    int ge;
    n  = 0;
    ge = (g == 0) ? 1 : g;
    for (int k = 1; k <= t + ge - 2; k++)
      if (hist[k] && !hist[k-1] && (k + 2 >= t + 1)) n++;
    return n;
  endfunction

  task automatic check_results(input string tag, input int t, input int g);
    int n;
    n = edges_in(t, g);
    check({tag, " done16"},  32'(done16), 32'd1);
    check({tag, " busy16"},  32'(busy16), 32'd0);
    check({tag, " count16"}, 32'(count16), (n > 65535) ? 32'd65535 : 32'(n));
    check({tag, " ovf16"},   32'(ovf16), (n > 65535) ? 32'd1 : 32'd0);
    check({tag, " done4"},   32'(done4), 32'd1);
    check({tag, " count4"},  32'(count4), (n > 15) ? 32'd15 : 32'(n));
    check({tag, " ovf4"},    32'(ovf4), (n > 15) ? 32'd1 : 32'd0);
  endtask

  // One single-shot window. stop is held so continuous builds also end after
  // one window. poke_at > 0 pulses start and changes gate_cycles mid-window.
  task automatic measure(input string tag, input int g, input int poke_at);
    int t;
    int ge;
    ge = (g == 0) ? 1 : g;
    gate_cycles = 16'(g);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    t = cyc;
    start = 1'b0;
    for (int i = 1; i <= ge; i++) begin
      check({tag, " busy in window"}, 32'(busy16), 32'd1);
      check({tag, " no early done"},  32'(done16), 32'd0);
      if (i == poke_at) begin
        start = 1'b1;
        gate_cycles = 16'd5;
      end
      tick();
      if (i == poke_at) begin
        start = 1'b0;
        gate_cycles = 16'(g);
      end
    end
    check_results(tag, t, g);
    stop = 1'b0;
    tick();
    check({tag, " done clears"}, 32'(done16), 32'd0);
    check({tag, " back idle"},   32'(busy16), 32'd0);
  endtask

  // Watch n cycles and require no done pulse and no busy.
  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done16 || busy16 || done4 || busy4) seen++;
    end
    check({tag, " stays idle"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int t;
    int g;
    rst = 1'b1;
    osc_in = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    gate_cycles = 16'd0;

    // Reset state
    repeat (3) tick();
    check("reset busy",     32'(busy16),  32'd0);
    check("reset done",     32'(done16),  32'd0);
    check("reset count",    32'(count16), 32'd0);
    check("reset overflow", 32'(ovf16),   32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic count: period 8, first rise one cycle after the start edge
    osc_p = 8;
    osc_ref = cyc + 1;
    measure("basic", 80, 0);
    check("basic literal count", 32'(count16), 32'd10);
    check("basic literal ovf",   32'(ovf16),   32'd0);

    // Saturation of the 4-bit accumulator
    osc_p = 4;
    osc_ref = cyc + 1;
    measure("saturate", 100, 0);
    check("saturate literal count4", 32'(count4), 32'd15);
    check("saturate literal ovf4",   32'(ovf4),   32'd1);

    // Zero window with a static oscillator
    osc_p = 0;
    repeat (4) tick();
    measure("zero", 0, 0);
    check("zero literal count", 32'(count16), 32'd0);

    // start and gate_cycles changes inside a 40-cycle window are ignored
    osc_p = 6;
    osc_ref = cyc;
    measure("ignored", 40, 10);
    quiet("ignored", 50);

    // Reset mid-window: abort at cycle T+20 of a 50-cycle window
    gate_cycles = 16'd50;
    start = 1'b1;
    tick();
    t = cyc;
    start = 1'b0;
    repeat (19) tick();
    check("pre-abort busy", 32'(busy16), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy",  32'(busy16),  32'd0);
    check("abort count", 32'(count16), 32'd0);
    check("abort done",  32'(done16),  32'd0);
    check("abort ovf4",  32'(ovf4),    32'd0);
    repeat (2) tick();
    rst = 1'b0;
    quiet("abort", 60);
    osc_p = 5;
    osc_ref = cyc;
    measure("after abort", 30, 0);
    if (t < 0) check("abort origin", 32'(t), 32'd0);

    // Randomized windows
    for (int r = 0; r < 4; r++) begin
      osc_p = int'($urandom_range(11, 4));
      osc_ref = cyc - int'($urandom_range(10, 0));
      g = int'($urandom_range(70, 1));
      repeat (int'($urandom_range(3, 0))) tick();
      measure($sformatf("random%0d", r), g, 0);
    end

`ifdef FREQ_METER_CONTINUOUS_EN
    // Continuous mode: back-to-back 16-cycle windows, stop raised in the fourth
    osc_p = 4;
    osc_ref = cyc + 1;
    gate_cycles = 16'd16;
    stop = 1'b0;
    start = 1'b1;
    tick();
    t = cyc;
    start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int i = 1; i <= 16; i++) begin
        check($sformatf("cont%0d busy", w), 32'(busy16), 32'd1);
        if (w == 3 && i == 5) stop = 1'b1;
        tick();
        stop = 1'b0;
      end
      check_results($sformatf("cont%0d", w), t + w * 17, 16);
      check($sformatf("cont%0d literal count", w), 32'(count16), 32'd4);
      tick();
    end
    check("cont stopped", 32'(busy16), 32'd0);
    quiet("cont after stop", 30);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
